// File: rtl/spart_pkg.sv
// SPART receiver shared types and default sizing.
// Optional parity support is enabled by defining SPART_RX_PARITY_EN.
package spart_pkg;

  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/spart_sync2.sv
// Two-flop synchronizer for asynchronous inputs, resets to 1 (idle line).
// Synchronous active-low reset.
module spart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/spart_rx.sv
// SPART receiver: oversampled start/data/stop framing, LSB first.
// Define SPART_RX_PARITY_EN to add an even-parity bit before the stop bit.
module spart_rx
  import spart_pkg::*;
#(
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int DATA_BITS  = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 rxd,
  input  logic                 rd_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rda,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 parity_err
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] T_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_END = BW'(DATA_BITS - 1);

  logic rxd_s;

  spart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxd_s)
  );

  rx_state_t state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic rda_q, rda_d;
  logic fe_q, fe_d;
  logic ov_q, ov_d;
  logic done;
`ifdef SPART_RX_PARITY_EN
  logic par_q, par_d;
  logic pe_q, pe_d;
`endif

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    rda_d   = rda_q;
    fe_d    = fe_q;
    ov_d    = ov_q;
    done    = 1'b0;
`ifdef SPART_RX_PARITY_EN
    par_d   = par_q;
    pe_d    = pe_q;
`endif
    if (rd_ack) rda_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rxd_s) begin
          state_d = START;
          tick_d  = '0;
        end
      end
      START: begin
        if (enable) begin
          if (tick_q == T_MID) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = rxd_s ? IDLE : DATA;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (enable) begin
          if (tick_q == T_END) begin
            tick_d  = '0;
            shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + 1'b1;
            if (bit_q == B_END) begin
`ifdef SPART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      PARITY: begin
`ifdef SPART_RX_PARITY_EN
        if (enable) begin
          if (tick_q == T_END) begin
            tick_d  = '0;
            par_d   = rxd_s;
            state_d = STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
`else
        state_d = IDLE;
`endif
      end
      STOP: begin
        if (enable) begin
          if (tick_q == T_END) begin
            tick_d  = '0;
            done    = 1'b1;
            state_d = rxd_s ? IDLE : BREAK;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      BREAK: begin
        // a held-low line must not look like a new start bit
        if (rxd_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (done) begin
      data_d = shift_q;
      fe_d   = ~rxd_s;
      ov_d   = rda_q & ~rd_ack;
      rda_d  = 1'b1;
`ifdef SPART_RX_PARITY_EN
      pe_d   = (^shift_q) ^ par_q;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      rda_q   <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
`ifdef SPART_RX_PARITY_EN
      par_q   <= 1'b0;
      pe_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      rda_q   <= rda_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
`ifdef SPART_RX_PARITY_EN
      par_q   <= par_d;
      pe_q    <= pe_d;
`endif
    end
  end

  assign rx_data   = data_q;
  assign rda       = rda_q;
  assign frame_err = fe_q;
  assign overrun   = ov_q;
`ifdef SPART_RX_PARITY_EN
  assign parity_err = pe_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_spart_rx.sv
// Self-checking bench for spart_rx: table of frames plus corner sequences.
// Honours SPART_RX_PARITY_EN for the parity frame format.
module tb_spart_rx;

  localparam int OS = 16;
  localparam int DB = 8;
`ifdef SPART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NT = 8 + OS * (DB + 1 + PAR);
  localparam int NV = 9;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       pbit;
    logic       pre_ack;
    logic       ack_done;
    logic [7:0] exp_data;
    logic       exp_rda;
    logic       exp_fe;
    logic       exp_ov;
    logic       exp_pe;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       rda;
    logic       fe;
    logic       ov;
    logic       pe;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       rxd = 1'b1;
  logic       rd_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rda;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;
  logic [1:0] div = 2'd0;

  int   checks = 0;
  int   errors = 0;
  vec_t tv [NV];
  exp_t sb [$];

  spart_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .rxd        (rxd),
    .rd_ack     (rd_ack),
    .rx_data    (rx_data),
    .rda        (rda),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    div    <= div + 2'd1;
    enable <= (div == 2'd3);
  end

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // called #1 after a posedge; returns #1 after the n-th enable edge
  task automatic wait_ticks(input int n);
    int c = 0;
    while (c < n) begin
      if (enable) c++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_ack();
    rd_ack = 1'b1;
    @(posedge clk);
    #1;
    rd_ack = 1'b0;
  endtask

  task automatic send_frame(input vec_t v);
    fork
      begin
        rxd = 1'b0;
        wait_ticks(OS);
        for (int i = 0; i < DB; i++) begin
          rxd = v.data[i];
          wait_ticks(OS);
        end
        if (PAR != 0) begin
          rxd = v.pbit;
          wait_ticks(OS);
        end
        rxd = v.stop;
        wait_ticks(OS);
      end
      begin
        if (v.ack_done) begin
          int k = 0;
          repeat (3) @(posedge clk);
          #1;
          wait_ticks(NT - 1);
          while (!enable && k < 8) begin
            @(posedge clk);
            #1;
            k++;
          end
          rd_ack = 1'b1;
          @(posedge clk);
          #1;
          rd_ack = 1'b0;
        end
      end
    join
  endtask

  task automatic check_frame(input string tag);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_sb: got empty queue expected entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_data"}, rx_data, e.d);
      chk({tag, "_rda"}, {7'd0, rda}, {7'd0, e.rda});
      chk({tag, "_fe"}, {7'd0, frame_err}, {7'd0, e.fe});
      chk({tag, "_ov"}, {7'd0, overrun}, {7'd0, e.ov});
      chk({tag, "_pe"}, {7'd0, parity_err}, {7'd0, e.pe});
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    tv[0] = '{8'h55, 1'b1, 1'b0, 1'b0, 1'b0,
              8'h55, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[1] = '{8'h12, 1'b1, 1'b0, 1'b1, 1'b0,
              8'h12, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[2] = '{8'h34, 1'b1, 1'b1, 1'b0, 1'b0,
              8'h34, 1'b1, 1'b0, 1'b1, 1'b0};
    tv[3] = '{8'h12, 1'b1, 1'b0, 1'b0, 1'b0,
              8'h12, 1'b1, 1'b0, 1'b1, 1'b0};
    tv[4] = '{8'h34, 1'b1, 1'b1, 1'b0, 1'b1,
              8'h34, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[5] = '{8'hA3, 1'b0, 1'b0, 1'b1, 1'b0,
              8'hA3, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[6] = '{8'hC6, 1'b1, 1'b0, 1'b0, 1'b0,
              8'hC6, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[7] = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b0,
              8'h07, 1'b1, 1'b0, 1'b1, 1'(PAR)};
    tv[8] = '{8'h07, 1'b1, 1'b1, 1'b0, 1'b0,
              8'h07, 1'b1, 1'b0, 1'b1, 1'b0};

    repeat (4) @(posedge clk);
    #1;
    chk("rst_data", rx_data, 8'h00);
    chk("rst_rda", {7'd0, rda}, 8'h00);
    chk("rst_fe", {7'd0, frame_err}, 8'h00);
    chk("rst_ov", {7'd0, overrun}, 8'h00);
    chk("rst_pe", {7'd0, parity_err}, 8'h00);
    rst = 1'b1;
    wait_ticks(20);

    for (int i = 0; i < NV; i++) begin
      if (tv[i].pre_ack) pulse_ack();
      sb.push_back('{tv[i].exp_data, tv[i].exp_rda, tv[i].exp_fe,
                     tv[i].exp_ov, tv[i].exp_pe});
      send_frame(tv[i]);
      check_frame($sformatf("vec%0d", i));
      if (!tv[i].stop) begin
        pulse_ack();
        wait_ticks(200);
        chk("brk_rda", {7'd0, rda}, 8'h00);
        chk("brk_data", rx_data, tv[i].exp_data);
        chk("brk_fe", {7'd0, frame_err}, 8'h01);
        rxd = 1'b1;
      end
      wait_ticks(4);
    end

    pulse_ack();
    rxd = 1'b0;
    wait_ticks(3);
    rxd = 1'b1;
    wait_ticks(200);
    chk("glitch_rda", {7'd0, rda}, 8'h00);
    chk("glitch_data", rx_data, tv[NV-1].exp_data);

    rxd = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 4; i++) begin
      rxd = i[0];
      wait_ticks(OS);
    end
    rxd = 1'b1;
    wait_ticks(OS / 2);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("mid_rst_data", rx_data, 8'h00);
    chk("mid_rst_rda", {7'd0, rda}, 8'h00);
    chk("mid_rst_fe", {7'd0, frame_err}, 8'h00);
    chk("mid_rst_ov", {7'd0, overrun}, 8'h00);
    chk("mid_rst_pe", {7'd0, parity_err}, 8'h00);
    wait_ticks(20);

    v = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b0,
          8'hFF, 1'b1, 1'b0, 1'b0, 1'b0};
    sb.push_back('{8'hFF, 1'b1, 1'b0, 1'b0, 1'b0});
    send_frame(v);
    check_frame("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spart_rx.md
Name: spart_rx

Overview:
- Receive half of the SPART serial port: oversamples `rxd`, frames start/data/stop, and presents one received byte plus a ready flag (`rda`) to the bus interface.
- Sits between the external `rxd` pin and the SPART bus-interface/driver.
- Timed by a one-cycle-wide `enable` tick from the baud generator, running at OVERSAMPLE x baud.
- 8N1 framing, LSB first.

Parameters:
- OVERSAMPLE, 16, number of `enable` ticks per bit period; must be even and >= 4.
- DATA_BITS, 8, data bits per frame; `rx_data` width.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-low reset
- enable  input  1  oversample tick from baud generator, one clk wide
- rxd  input  1  asynchronous serial input, idle high
- rd_ack  input  1  one-cycle pulse: bus read of receive buffer, clears `rda`
- rx_data  output  DATA_BITS  last completed byte, held until the next byte completes
- rda  output  1  received data available
- frame_err  output  1  stop bit of last frame sampled low
- overrun  output  1  byte completed while `rda` was still set and unacknowledged
- parity_err  output  1  parity mismatch; tied 0 unless PARITY_EN

Behaviour:
- Reset (rst==0 at posedge clk):
  - state=IDLE, all counters 0.
  - synchronizer flops=1.
  - rx_data=0, rda=0, frame_err=0, overrun=0, parity_err=0.
- rxd passes through a 2-flop synchronizer (rxd_s); 2 clk latency. All decisions use rxd_s.
- tick_cnt (log2 OVERSAMPLE bits) advances only on cycles with enable=1.
- IDLE:
  - rxd_s==0 -> START, tick_cnt=0. Detection does not wait for enable.
- START:
  - On an enable tick with tick_cnt==OVERSAMPLE/2-1 (mid start bit): rxd_s==0 -> DATA (tick_cnt=0, bit_idx=0); rxd_s==1 -> false start, back to IDLE, no flags touched.
- DATA:
  - On an enable tick with tick_cnt==OVERSAMPLE-1: shift rxd_s into shift register MSB, shifting right (LSB-first reception); tick_cnt=0.
  - After bit_idx==DATA_BITS-1 -> STOP (or PARITY when PARITY_EN).
- STOP, on an enable tick with tick_cnt==OVERSAMPLE-1:
  - rx_data <= shift register.
  - frame_err <= ~rxd_s.
  - overrun <= rda & ~rd_ack.
  - rda <= 1.
  - Next state: rxd_s==1 -> IDLE; rxd_s==0 -> BREAK.
- BREAK:
  - Wait for rxd_s==1, then IDLE. Prevents a low line being re-detected as a start bit.
- Flag updates on byte completion:
  - frame_err, overrun and parity_err are all updated on every completed byte; each is sticky only until that next completion.
- rda:
  - rd_ack with no completion in the same cycle -> rda=0 next cycle; rx_data is unchanged.
  - rd_ack and byte completion in the same cycle: completion wins, so rda stays 1 and overrun=0.
- enable low for long stretches freezes tick_cnt and the state; this is not an error.
- Reset mid-frame aborts the frame; no partial byte is ever written to rx_data.

Optional Feature:
- Macro: SPART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP, one bit period long, sampled at tick_cnt==OVERSAMPLE-1.
  - Parity is even: parity_err <= (^shift_reg) ^ parity_bit, updated at byte completion.
- Undefined:
  - No PARITY state; frame is 8N1.
  - parity_err is constant 0.

Decomposition:
- Package spart_pkg holds:
  - state enum rx_state_t {IDLE, START, DATA, PARITY, STOP, BREAK};
  - OVERSAMPLE default constant;
  - DATA_BITS default constant.
- One natural sub-module: spart_sync2 (2-flop synchronizer with reset value 1), reusable for the CTS/other async inputs.

Test Plan:
- Byte 0x55, enable every 4 clk, OVERSAMPLE=16, clean 8N1 frame -> rx_data=0x55, rda=1, frame_err=0, overrun=0 about 10 bit periods after the start edge.
- Glitch: rxd low for 3 enable ticks then high -> state returns to IDLE, rda stays 0, rx_data unchanged.
- Frame with stop bit held low, byte 0xA3 -> rx_data=0xA3, rda=1, frame_err=1; no new frame is detected until rxd returns high.
- Back-to-back 0x12 then 0x34 with no rd_ack -> rx_data=0x34, overrun=1.
- Repeat the previous case with rd_ack pulsed on the completion cycle of 0x34 -> rda=1, overrun=0.
- Reset (rst=0 for 1 clk) in the middle of data bit 4 -> all outputs 0; the next full frame 0xFF is received correctly.
- With SPART_RX_PARITY_EN, byte 0x07 (odd popcount) sent with parity bit 0 -> parity_err=1. With parity bit 1 -> parity_err=0.
